// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared encodings for the multicycle MIPS control unit: FSM state enum,
// opcode and funct constants, ALUControl codes, the ALU-op selector
// handed to alu_decoder, and the ALUSrcB / PCSrc mux select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    // opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALUControl codes driven to the ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // what the FSM asks of the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // ALUSrcB select
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PCSrc select
    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// alu_decoder
// Combinational ALUControl generation.
//   alu_op        in  2  add / sub / decode-from-funct request from the FSM
//   funct         in  6  instruction[5:0]
//   alu_control   out 3  code for the ALU
//   funct_illegal out 1  funct not supported (only raised for ALUOP_FUNCT)
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_t      alu_op,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_control,
    output logic        funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    // unsupported funct leaves the ALU on a harmless add
                    default:   funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Moore control FSM for the multicycle MIPS datapath. Sequences
// fetch/decode/execute/memory/writeback and drives the datapath selects
// and write enables; ALUControl comes from alu_decoder.
// Ports:
//   clk, reset (async, active-high)
//   op, funct     in  6  instruction fields from the IR
//   zero          in  1  ALU zero flag (same cycle, used for branches)
//   ALUControl    out 3  ALU operation
//   ALUSrcA/ALUSrcB, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
//   RegWrite, PCSrc   datapath controls
//   PCEn          out 1  PCWrite | (Branch & branch_taken)
//   illegal_op    out 1  pulse on unsupported op (DECODE) or funct (EXECUTE)
// Build option: define MIPS_BNE_EN to support bne (op 000101); otherwise
// bne decodes as illegal.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | after reset, all outputs low
// FETCH   | read instruction, PC <= PC + 4
// DECODE  | branch target into ALUOut, dispatch on op
// MEMADR  | lw/sw effective address
// MEMRD   | data memory read
// MEMWB   | load data to rt
// MEMWR   | data memory write
// EXECUTE | R-type ALU operation
// ALUWB   | ALU result to rd
// BRANCH  | compare, PC <= ALUOut if taken
// ADDIEX  | rs + signimm
// ADDIWB  | ALU result to rt
// JUMP    | PC <= jump target
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic [2:0]  ALUControl,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic [1:0]  PCSrc,
    output logic        PCEn,
    output logic        illegal_op
);

    state_t state_q, state_d;
    aluop_t alu_op;
    logic   funct_illegal;
    logic   pc_write;
    logic   branch;
    logic   branch_taken;

`ifdef MIPS_BNE_EN
    // branch sense: set in DECODE for bne, cleared every FETCH
    logic   bne_q, bne_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bne_q <= 1'b0;
        else       bne_q <= bne_d;
    end

    always_comb begin
        bne_d = bne_q;
        if (state_q == S_FETCH)       bne_d = 1'b0;
        else if (state_q == S_DECODE) bne_d = (op == OP_BNE);
    end

    assign branch_taken = bne_q ? ~zero : zero;
`else
    assign branch_taken = zero;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (funct),
        .alu_control   (ALUControl),
        .funct_illegal (funct_illegal)
    );

    always_comb begin
        state_d    = state_q;
        alu_op     = ALUOP_ADD;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        PCSrc      = PCSRC_ALURESULT;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                IRWrite  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMMSH2;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_FUNCT;
                illegal_op = funct_illegal;
                // a bad funct must not reach the register file
                state_d    = funct_illegal ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSrc    = PCSRC_JUMP;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign PCEn = pc_write | (branch & branch_taken);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: directed instructions, a reset in
// the middle of a store, then random instruction streams, each compared
// cycle by cycle against an instruction-level reference model.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic [2:0]  ALUControl;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic [1:0]  PCSrc;
    logic        PCEn, illegal_op;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .illegal_op (illegal_op)
    );

    // {ALUControl, ALUSrcA, ALUSrcB, IorD, MemWrite, IRWrite, RegDst,
    //  MemtoReg, RegWrite, PCSrc, PCEn, illegal_op}
    logic [15:0] outs;
    assign outs = {ALUControl, ALUSrcA, ALUSrcB, IorD, MemWrite, IRWrite,
                   RegDst, MemtoReg, RegWrite, PCSrc, PCEn, illegal_op};

    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %04h want %04h (alu,srca,srcb,iord,mw,irw,rd,m2r,rw,pcsrc,pcen,ill)",
                     tag, got, want);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] alu, input logic sa,
                                       input logic [1:0] sb, input logic iord,
                                       input logic mw, input logic irw,
                                       input logic rd, input logic m2r,
                                       input logic rw, input logic [1:0] pcs,
                                       input logic pce, input logic ill);
        return {alu, sa, sb, iord, mw, irw, rd, m2r, rw, pcs, pce, ill};
    endfunction

    // Expected per-cycle control words for one instruction, from its
    // architectural meaning: fetch, decode, then class-specific steps.
    task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z);
        logic [2:0] fa;
        logic       fok;
        logic [15:0] dec_ok, dec_bad;
        dec_ok  = mk(3'b000, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        dec_bad = mk(3'b000, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        exp_q.push_back(mk(3'b000, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0));
        case (o)
            6'b100011: begin
                exp_q.push_back(dec_ok);
                exp_q.push_back(mk(3'b000, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
                exp_q.push_back(mk(3'b000, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
                exp_q.push_back(mk(3'b000, 0, 2'b00, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0));
            end
            6'b101011: begin
                exp_q.push_back(dec_ok);
                exp_q.push_back(mk(3'b000, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
                exp_q.push_back(mk(3'b000, 0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0));
            end
            6'b000000: begin
                fok = 1'b1;
                case (f)
                    6'b100000: fa = 3'b000;
                    6'b100010: fa = 3'b001;
                    6'b100100: fa = 3'b010;
                    6'b100101: fa = 3'b011;
                    6'b101010: fa = 3'b101;
                    default: begin fa = 3'b000; fok = 1'b0; end
                endcase
                exp_q.push_back(dec_ok);
                exp_q.push_back(mk(fa, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, !fok));
                if (fok)
                    exp_q.push_back(mk(3'b000, 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0));
            end
            6'b000100: begin
                exp_q.push_back(dec_ok);
                exp_q.push_back(mk(3'b001, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, z, 0));
            end
`ifdef MIPS_BNE_EN
            6'b000101: begin
                exp_q.push_back(dec_ok);
                exp_q.push_back(mk(3'b001, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, !z, 0));
            end
`endif
            6'b001000: begin
                exp_q.push_back(dec_ok);
                exp_q.push_back(mk(3'b000, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
                exp_q.push_back(mk(3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0));
            end
            6'b000010: begin
                exp_q.push_back(dec_ok);
                exp_q.push_back(mk(3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0));
            end
            default: exp_q.push_back(dec_bad);
        endcase
    endtask

    // Runs one instruction from FETCH; checks between clock edges.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input logic z, input string nm);
        exp_q.delete();
        build(o, f, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            op = o; funct = f; zero = z;
            #1;
            chk($sformatf("%s cyc%0d", nm, i + 1), outs, exp_q[i]);
        end
    endtask

    localparam logic [5:0] VALID_F [5] = '{6'b100000, 6'b100010, 6'b100100,
                                            6'b100101, 6'b101010};
    localparam logic [5:0] VALID_OP [6] = '{6'b100011, 6'b101011, 6'b000000,
                                             6'b000100, 6'b001000, 6'b000010};

    initial begin
        logic [5:0] ro, rf;
        logic       rz;

        // reset held from time 0
        repeat (2) begin
            @(negedge clk); #1;
            chk("reset", outs, 16'h0000);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle", outs, 16'h0000);

        run_instr(6'b100011, 6'b000000, 1'b0, "lw");
        run_instr(6'b000000, 6'b101010, 1'b0, "slt");
        run_instr(6'b000000, 6'b111111, 1'b0, "bad_funct");
        run_instr(6'b000100, 6'b000000, 1'b1, "beq_taken");
        run_instr(6'b000100, 6'b000000, 1'b0, "beq_not");
        run_instr(6'b000101, 6'b000000, 1'b0, "bne_z0");
        run_instr(6'b000101, 6'b000000, 1'b1, "bne_z1");
        run_instr(6'b000010, 6'b000000, 1'b0, "j");
        run_instr(6'b101011, 6'b000000, 1'b0, "sw");
        run_instr(6'b001000, 6'b000000, 1'b1, "addi");

        // reset for 3 cycles while a store sits in its write cycle
        exp_q.delete();
        build(6'b101011, 6'b000000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op = 6'b101011; funct = '0; zero = 1'b0;
            #1;
            chk($sformatf("sw_rst cyc%0d", i + 1), outs, exp_q[i]);
        end
        #1 reset = 1'b1;
        #1 chk("rst_in_memwr", outs, 16'h0000);
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_held", outs, 16'h0000);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_after_rst", outs, 16'h0000);
        run_instr(6'b100011, 6'b000000, 1'b1, "lw_after_rst");

        // random instruction stream
        for (int n = 0; n < 300; n++) begin
            rz = 1'($urandom_range(0, 1));
            rf = 6'($urandom);
            case ($urandom_range(0, 5))
                0, 1, 2: ro = VALID_OP[$urandom_range(0, 5)];
                3: begin
                    ro = 6'b000000;
                    rf = VALID_F[$urandom_range(0, 4)];
                end
                4: ro = 6'b000101;
                default: ro = 6'($urandom);
            endcase
            run_instr(ro, rf, rz, $sformatf("rnd%0d op%02h f%02h", n, ro, rf));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
